mano_ac_datapath: RTL and testbench
===================================

# mano_ac_datapath

Accumulator-side datapath of the Mano basic computer: 16-bit accumulator (AC), 16-bit data register (DR), extend flip-flop (E), and the combinational AC arithmetic/logic unit that feeds AC. The control unit drives its one-hot micro-operation strobes. The common bus supplies DR load data. AC and DR drive the bus mux and the control unit's skip/condition logic.

## Interface
Parameters: none (fixed 16-bit word, 8-bit input character).

- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- bus_data  in  16  common-bus value, DR load source
- INPR  in  8  input character register
- CLRAC, INRAC, LoadAC  in  1 each  AC clear / increment / load-from-ALU
- CLRDR, INRDR, LoadDR  in  1 each  DR clear / increment / load-from-bus
- AND, ADD, LDA, COM, SHR, SHL, INPT  in  1 each  ALU function selects
- CLE, CME  in  1 each  clear / complement E
- AC  out  16  accumulator, registered
- DR  out  16  data register, registered
- E  out  1  extend flip-flop, registered
- cout  out  1  carry-out of AC+DR, combinational
- AC_zero  out  1  AC == 0x0000
- AC_neg  out  1  AC[15]
- DR_zero  out  1  DR == 0x0000

## Operation
ALU result ACDATA is combinational. It uses fixed priority when several selects are high:
- AND: AC & DR
- ADD: (AC + DR)[15:0]
- LDA: DR
- COM: ~AC
- SHR: {E, AC[15:1]} (circular right through E)
- SHL: {AC[14:0], E} (circular left through E)
- INPT: {AC[15:8], INPR}
- none asserted: AC (hold)

cout is always the bit-16 carry of the 17-bit sum AC + DR, regardless of which select is active.

AC next-state priority: RST → 0x0000; CLRAC → 0x0000; LoadAC → ACDATA; INRAC → AC+1, wrapping 0xFFFF→0x0000 with E unaffected; else hold.

DR next-state priority: RST → 0x0000; CLRDR → 0x0000; LoadDR → bus_data; INRDR → DR+1, wrapping 0xFFFF→0x0000; else hold.

E next-state priority:
- RST → 0.
- LoadAC with winning select ADD → cout; SHR → AC[0]; SHL → AC[15].
- CLE → 0.
- CME → ~E.
- Else hold. CLE/CME are ignored in a cycle where an E-writing ALU load occurs.

AC_zero, AC_neg and DR_zero are derived combinationally from the registered AC/DR.

## Timing
- Single clock domain. Every register updates on the rising CLK edge, one-cycle latency from strobe to output.
- ALU, cout and the flags have zero-cycle combinational paths from current register values.
- RST is sampled only on the clock edge. It overrides every strobe in the same cycle, including mid-sequence: AC=DR=0x0000 and E=0 on the next edge. Outputs are undefined until the first reset edge.
- Simultaneous LoadDR and LoadAC+LDA in one cycle: AC receives the old DR value, because DR has not yet updated.
- Strobes are level-sampled per cycle. Holding LoadAC high for N cycles applies the operation N times; for example, ADD accumulates.
- No handshake. The control unit guarantees strobe timing.

## Configuration
- MANO_INPT_EN defined: INPT function and INPR path active as specified.
- MANO_INPT_EN undefined: INPR and INPT ports remain but are ignored. INPT is treated as deasserted in the select priority, so LoadAC with only INPT holds AC. No logic is generated for the INPR path.

## Test plan
- Reset: drive AC/DR/E nonzero, pulse RST 1 cycle → AC=0x0000, DR=0x0000, E=0, AC_zero=1, DR_zero=1.
- Load/add: LoadDR bus=0x0001, then LoadAC+LDA → AC=0x0001. Then LoadDR bus=0x0002, then LoadAC+ADD → AC=0x0003, E=0.
- Carry/wrap: AC=0xFFFF, DR=0x0001, LoadAC+ADD → AC=0x0000, E=1, AC_zero=1. Separately, AC=0xFFFF with INRAC → AC=0x0000, E unchanged.
- Shifts: AC=0x8001, E=0, LoadAC+SHR → AC=0x4000, E=1. Then LoadAC+SHL → AC=0x8001, E=0, AC_neg=1.
- Logic/priority: AC=0x00F0, LoadAC+COM → 0xFF0F. DR=0x0F0F, LoadAC+AND → 0x0F0F. AND+ADD together → AND result. CLRAC+LoadAC → 0x0000.
- Input: AC=0x1234, INPR=0x5A, LoadAC+INPT → AC=0x125A with MANO_INPT_EN; AC stays 0x1234 without it.

Source files
------------

// File: rtl/mano_ac_datapath.sv
// Accumulator-side datapath of the Mano basic computer: AC, DR, E and the AC ALU.
// Optional INPT/INPR path is built only when MANO_INPT_EN is defined.
module mano_ac_datapath (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] bus_data,
    input  logic [7:0]  INPR,
    input  logic        CLRAC,
    input  logic        INRAC,
    input  logic        LoadAC,
    input  logic        CLRDR,
    input  logic        INRDR,
    input  logic        LoadDR,
    input  logic        AND,
    input  logic        ADD,
    input  logic        LDA,
    input  logic        COM,
    input  logic        SHR,
    input  logic        SHL,
    input  logic        INPT,
    input  logic        CLE,
    input  logic        CME,
    output logic [15:0] AC,
    output logic [15:0] DR,
    output logic        E,
    output logic        cout,
    output logic        AC_zero,
    output logic        AC_neg,
    output logic        DR_zero
);

    // No handshake: strobes are level-sampled every cycle; the control unit owns their timing.
    logic [16:0] sum;
    logic [15:0] ac_data;
    logic        e_write;
    logic        e_data;

    assign sum     = {1'b0, AC} + {1'b0, DR};
    assign cout    = sum[16];
    assign AC_zero = (AC == 16'h0000);
    assign AC_neg  = AC[15];
    assign DR_zero = (DR == 16'h0000);

`ifndef MANO_INPT_EN
    logic unused_inpt;
    assign unused_inpt = ^{INPR, INPT};
`endif

    // Fixed-priority ALU; e_write marks functions whose load also updates E.
    always_comb begin
        ac_data = AC;
        e_write = 1'b0;
        e_data  = E;
        if (AND) begin
            ac_data = AC & DR;
        end else if (ADD) begin
            ac_data = sum[15:0];
            e_write = 1'b1;
            e_data  = sum[16];
        end else if (LDA) begin
            ac_data = DR;
        end else if (COM) begin
            ac_data = ~AC;
        end else if (SHR) begin
            ac_data = {E, AC[15:1]};
            e_write = 1'b1;
            e_data  = AC[0];
        end else if (SHL) begin
            ac_data = {AC[14:0], E};
            e_write = 1'b1;
            e_data  = AC[15];
`ifdef MANO_INPT_EN
        end else if (INPT) begin
            ac_data = {AC[15:8], INPR};
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            AC <= 16'h0000;
        end else if (CLRAC) begin
            AC <= 16'h0000;
        end else if (LoadAC) begin
            AC <= ac_data;
        end else if (INRAC) begin
            AC <= AC + 16'h0001;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DR <= 16'h0000;
        end else if (CLRDR) begin
            DR <= 16'h0000;
        end else if (LoadDR) begin
            DR <= bus_data;
        end else if (INRDR) begin
            DR <= DR + 16'h0001;
        end
    end

    // An E-writing ALU load takes precedence over CLE/CME in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            E <= 1'b0;
        end else if (LoadAC && e_write) begin
            E <= e_data;
        end else if (CLE) begin
            E <= 1'b0;
        end else if (CME) begin
            E <= ~E;
        end
    end

endmodule

// File: tb/tb_mano_ac_datapath.sv
// Directed, table-driven bench for mano_ac_datapath; expected INPT result
// depends on whether MANO_INPT_EN is defined for the build.
module tb_mano_ac_datapath;

    // Strobe mask bit positions.
    localparam logic [15:0] S_CLRAC  = 16'h0001;
    localparam logic [15:0] S_INRAC  = 16'h0002;
    localparam logic [15:0] S_LOADAC = 16'h0004;
    localparam logic [15:0] S_CLRDR  = 16'h0008;
    localparam logic [15:0] S_INRDR  = 16'h0010;
    localparam logic [15:0] S_LOADDR = 16'h0020;
    localparam logic [15:0] S_AND    = 16'h0040;
    localparam logic [15:0] S_ADD    = 16'h0080;
    localparam logic [15:0] S_LDA    = 16'h0100;
    localparam logic [15:0] S_COM    = 16'h0200;
    localparam logic [15:0] S_SHR    = 16'h0400;
    localparam logic [15:0] S_SHL    = 16'h0800;
    localparam logic [15:0] S_INPT   = 16'h1000;
    localparam logic [15:0] S_CLE    = 16'h2000;
    localparam logic [15:0] S_CME    = 16'h4000;
    localparam logic [15:0] S_RST    = 16'h8000;

`ifdef MANO_INPT_EN
    localparam logic [15:0] INPT_EXP = 16'h125A;
`else
    localparam logic [15:0] INPT_EXP = 16'h1234;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] bus_data;
    logic [7:0]  INPR;
    logic        CLRAC, INRAC, LoadAC, CLRDR, INRDR, LoadDR;
    logic        AND, ADD, LDA, COM, SHR, SHL, INPT, CLE, CME;
    logic [15:0] AC, DR;
    logic        E, cout, AC_zero, AC_neg, DR_zero;

    typedef struct {
        logic [15:0] st;
        logic [15:0] bus;
        logic [7:0]  inpr;
        logic [15:0] ac;
        logic [15:0] dr;
        logic        e;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    mano_ac_datapath dut (
        .CLK(CLK), .RST(RST), .bus_data(bus_data), .INPR(INPR),
        .CLRAC(CLRAC), .INRAC(INRAC), .LoadAC(LoadAC),
        .CLRDR(CLRDR), .INRDR(INRDR), .LoadDR(LoadDR),
        .AND(AND), .ADD(ADD), .LDA(LDA), .COM(COM), .SHR(SHR), .SHL(SHL),
        .INPT(INPT), .CLE(CLE), .CME(CME),
        .AC(AC), .DR(DR), .E(E), .cout(cout),
        .AC_zero(AC_zero), .AC_neg(AC_neg), .DR_zero(DR_zero)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic set_inputs(input logic [15:0] st, input logic [15:0] bus, input logic [7:0] inpr);
        {RST, CME, CLE, INPT, SHL, SHR, COM, LDA, ADD, AND,
         LoadDR, INRDR, CLRDR, LoadAC, INRAC, CLRAC} = st;
        bus_data = bus;
        INPR     = inpr;
    endtask

    // Drive one cycle of strobes, then sample just after the rising edge.
    task automatic step(input logic [15:0] st, input logic [15:0] bus, input logic [7:0] inpr);
        @(negedge CLK);
        set_inputs(st, bus, inpr);
        @(posedge CLK);
        #1;
        set_inputs(16'h0000, 16'h0000, 8'h00);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] ac, input logic [15:0] dr, input logic e);
        logic [16:0] s;
        s = {1'b0, ac} + {1'b0, dr};
        chk({tag, " AC"}, {16'h0, AC}, {16'h0, ac});
        chk({tag, " DR"}, {16'h0, DR}, {16'h0, dr});
        chk({tag, " E"}, {31'h0, E}, {31'h0, e});
        chk({tag, " AC_zero"}, {31'h0, AC_zero}, {31'h0, (ac == 16'h0)});
        chk({tag, " AC_neg"}, {31'h0, AC_neg}, {31'h0, ac[15]});
        chk({tag, " DR_zero"}, {31'h0, DR_zero}, {31'h0, (dr == 16'h0)});
        chk({tag, " cout"}, {31'h0, cout}, {31'h0, s[16]});
    endtask

    task automatic add_vec(input logic [15:0] st, input logic [15:0] bus, input logic [7:0] inpr,
                           input logic [15:0] ac, input logic [15:0] dr, input logic e);
        vec_t v;
        v.st = st; v.bus = bus; v.inpr = inpr; v.ac = ac; v.dr = dr; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        set_inputs(16'h0000, 16'h0000, 8'h00);

        // Each row: strobes, bus, INPR -> expected AC, DR, E after the edge.
        add_vec(S_RST,                      16'h0000, 8'h00, 16'h0000, 16'h0000, 1'b0);
        add_vec(S_LOADDR,                   16'h0001, 8'h00, 16'h0000, 16'h0001, 1'b0);
        add_vec(S_LOADAC | S_LDA,           16'h0000, 8'h00, 16'h0001, 16'h0001, 1'b0);
        add_vec(S_LOADDR,                   16'h0002, 8'h00, 16'h0001, 16'h0002, 1'b0);
        add_vec(S_LOADAC | S_ADD,           16'h0000, 8'h00, 16'h0003, 16'h0002, 1'b0);
        add_vec(S_LOADDR,                   16'hFFFF, 8'h00, 16'h0003, 16'hFFFF, 1'b0);
        add_vec(S_LOADAC | S_LDA,           16'h0000, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0);
        add_vec(S_LOADDR,                   16'h0001, 8'h00, 16'hFFFF, 16'h0001, 1'b0);
        add_vec(S_LOADAC | S_ADD,           16'h0000, 8'h00, 16'h0000, 16'h0001, 1'b1);
        add_vec(S_LOADDR | S_LOADAC | S_LDA, 16'hFFFF, 8'h00, 16'h0001, 16'hFFFF, 1'b1);
        add_vec(S_LOADAC | S_LDA,           16'h0000, 8'h00, 16'hFFFF, 16'hFFFF, 1'b1);
        add_vec(S_INRAC,                    16'h0000, 8'h00, 16'h0000, 16'hFFFF, 1'b1);
        add_vec(S_INRDR,                    16'h0000, 8'h00, 16'h0000, 16'h0000, 1'b1);
        add_vec(S_CME,                      16'h0000, 8'h00, 16'h0000, 16'h0000, 1'b0);
        add_vec(S_LOADDR,                   16'h8001, 8'h00, 16'h0000, 16'h8001, 1'b0);
        add_vec(S_LOADAC | S_LDA,           16'h0000, 8'h00, 16'h8001, 16'h8001, 1'b0);
        add_vec(S_LOADAC | S_SHR,           16'h0000, 8'h00, 16'h4000, 16'h8001, 1'b1);
        add_vec(S_LOADAC | S_SHL,           16'h0000, 8'h00, 16'h8001, 16'h8001, 1'b0);
        add_vec(S_LOADDR,                   16'h00F0, 8'h00, 16'h8001, 16'h00F0, 1'b0);
        add_vec(S_LOADAC | S_LDA,           16'h0000, 8'h00, 16'h00F0, 16'h00F0, 1'b0);
        add_vec(S_LOADAC | S_COM,           16'h0000, 8'h00, 16'hFF0F, 16'h00F0, 1'b0);
        add_vec(S_LOADDR,                   16'h0F0F, 8'h00, 16'hFF0F, 16'h0F0F, 1'b0);
        add_vec(S_LOADAC | S_AND,           16'h0000, 8'h00, 16'h0F0F, 16'h0F0F, 1'b0);
        add_vec(S_LOADDR,                   16'h00FF, 8'h00, 16'h0F0F, 16'h00FF, 1'b0);
        add_vec(S_LOADAC | S_AND | S_ADD,   16'h0000, 8'h00, 16'h000F, 16'h00FF, 1'b0);
        add_vec(S_CLRAC | S_LOADAC | S_LDA, 16'h0000, 8'h00, 16'h0000, 16'h00FF, 1'b0);
        add_vec(S_CME,                      16'h0000, 8'h00, 16'h0000, 16'h00FF, 1'b1);
        add_vec(S_CLE | S_CME,              16'h0000, 8'h00, 16'h0000, 16'h00FF, 1'b0);
        add_vec(S_CME,                      16'h0000, 8'h00, 16'h0000, 16'h00FF, 1'b1);
        add_vec(S_LOADAC | S_SHL | S_CME,   16'h0000, 8'h00, 16'h0001, 16'h00FF, 1'b0);
        add_vec(S_LOADDR,                   16'h1234, 8'h00, 16'h0001, 16'h1234, 1'b0);
        add_vec(S_LOADAC | S_LDA,           16'h0000, 8'h00, 16'h1234, 16'h1234, 1'b0);
        add_vec(S_LOADAC | S_INPT,          16'h0000, 8'h5A, INPT_EXP, 16'h1234, 1'b0);
        add_vec(S_LOADAC,                   16'h0000, 8'h00, INPT_EXP, 16'h1234, 1'b0);
        add_vec(S_CLRDR | S_LOADDR,         16'h5555, 8'h00, INPT_EXP, 16'h0000, 1'b0);
        add_vec(S_LOADDR | S_INRDR,         16'h0007, 8'h00, INPT_EXP, 16'h0007, 1'b0);
        add_vec(S_RST | S_LOADAC | S_COM | S_CME | S_LOADDR, 16'hAAAA, 8'h00, 16'h0000, 16'h0000, 1'b0);

        // Reset from a nonzero state.
        step(S_RST, 16'h0000, 8'h00);
        step(S_LOADDR, 16'hBEEF, 8'h00);
        step(S_LOADAC | S_LDA | S_CME, 16'h0000, 8'h00);
        chk_state("pre_rst", 16'hBEEF, 16'hBEEF, 1'b1);
        step(S_RST, 16'h0000, 8'h00);
        chk_state("rst", 16'h0000, 16'h0000, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].bus, tbl[i].inpr);
            chk_state($sformatf("v%0d", i), tbl[i].ac, tbl[i].dr, tbl[i].e);
        end

        // Holding LoadAC+ADD for several cycles accumulates DR into AC.
        step(S_LOADDR, 16'h0005, 8'h00);
        exp_q.push_back(16'h0005);
        exp_q.push_back(16'h000A);
        exp_q.push_back(16'h000F);
        @(negedge CLK);
        set_inputs(S_LOADAC | S_ADD, 16'h0000, 8'h00);
        for (int c = 0; c < 3; c++) begin
            logic [15:0] exp_ac;
            @(posedge CLK);
            #1;
            exp_ac = exp_q.pop_front();
            chk($sformatf("accum%0d AC", c), {16'h0, AC}, {16'h0, exp_ac});
            chk($sformatf("accum%0d E", c), {31'h0, E}, 32'h0);
        end
        @(negedge CLK);
        set_inputs(16'h0000, 16'h0000, 8'h00);

        // Reset asserted in the middle of a held accumulate.
        set_inputs(S_LOADAC | S_ADD | S_RST, 16'h0000, 8'h00);
        @(posedge CLK);
        #1;
        chk_state("mid_rst", 16'h0000, 16'h0000, 1'b0);
        set_inputs(16'h0000, 16'h0000, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
